// File: rtl/controller_sequencer_pkg.sv
// Shared SAP-1 constants: opcodes, control-word bit positions and fixed words.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a; the sequencer is free-running and has no handshake.
package sap1_pkg;

  localparam int T_STATES = 6;
  localparam int CW_W     = 12;

  typedef logic [CW_W-1:0]     cw_t;
  typedef logic [T_STATES-1:0] tstate_t;
  typedef logic [3:0]          opcode_t;

  localparam opcode_t OP_LDA = 4'b0000;
  localparam opcode_t OP_ADD = 4'b0001;
  localparam opcode_t OP_SUB = 4'b0010;
  localparam opcode_t OP_OUT = 4'b1110;
  localparam opcode_t OP_HLT = 4'b1111;

  // Bit positions inside control_word; MSB is Cp.
  localparam int CW_CP   = 11;
  localparam int CW_EP   = 10;
  localparam int CW_LM_N = 9;
  localparam int CW_CE_N = 8;
  localparam int CW_LI_N = 7;
  localparam int CW_EI_N = 6;
  localparam int CW_LA_N = 5;
  localparam int CW_EA   = 4;
  localparam int CW_SU   = 3;
  localparam int CW_EU   = 2;
  localparam int CW_LB_N = 1;
  localparam int CW_LO_N = 0;

  // All strobes idle: active-low bits high, active-high bits low.
  localparam cw_t CW_INACTIVE = 12'b0_0_1_1_1_1_1_0_0_0_1_1;

  // Fetch words, common to every opcode.
  localparam cw_t CW_T1 = 12'b0_1_0_1_1_1_1_0_0_0_1_1; // Ep, Lm_n
  localparam cw_t CW_T2 = 12'b1_0_1_1_1_1_1_0_0_0_1_1; // Cp
  localparam cw_t CW_T3 = 12'b0_0_1_0_0_1_1_0_0_0_1_1; // CE_n, Li_n

  // Drive one control bit to its active level, whatever its polarity.
  function automatic cw_t cw_on(input cw_t w, input int idx);
    cw_t r;
    r      = w;
    r[idx] = ~CW_INACTIVE[idx];
    return r;
  endfunction

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// Six-position one-hot ring counter (T1..T6), advances one position per clock.
// Latency: new position visible one clock after the edge; reset is immediate.
// Backpressure: hold freezes the ring in place (used once the machine halts).
module ring_counter
  import sap1_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    hold,
  output tstate_t t_state
);

  // Rotate left one place per clock unless held; reset parks the ring at T1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_state <= tstate_t'(1);
    end else if (!hold) begin
      t_state <= {t_state[T_STATES-2:0], t_state[T_STATES-1]};
    end
  end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: T-state ring plus opcode decode into the 12-bit control word.
// Latency: control word is combinational from T state/opcode; one instruction per 6 clocks.
// Backpressure: none; once HLT is decoded the ring freezes at T4 until reset.
module controller_sequencer
  import sap1_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  output logic [11:0] control_word,
  output logic [5:0]  t_state,
  output logic        halt
);

  logic halt_next;
  cw_t  cw;

  // The ring must already be held on the edge that ends T4 of HLT, so it is
  // driven from the next-state halt rather than the registered one.
  ring_counter u_ring (
    .clk     (clk),
    .reset   (reset),
    .hold    (halt_next),
    .t_state (t_state)
  );

  // Halt state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt <= 1'b0;
    end else begin
      halt <= halt_next;
    end
  end

  // Halt is sticky and is entered only from T4 with HLT in the instruction register.
  always_comb begin
    halt_next = halt;
    if (t_state[3] && (opcode == OP_HLT)) begin
      halt_next = 1'b1;
    end
  end

  // Control-word decode; opcode only matters during T4..T6 and is ignored when halted.
  always_comb begin
    cw = CW_INACTIVE;
    if (halt) begin
      cw = CW_INACTIVE;
    end else if (t_state[0]) begin
      cw = CW_T1;
    end else if (t_state[1]) begin
      cw = CW_T2;
    end else if (t_state[2]) begin
      cw = CW_T3;
    end else if (t_state[3]) begin
      unique case (opcode)
        OP_LDA, OP_ADD, OP_SUB: cw = cw_on(cw_on(CW_INACTIVE, CW_EI_N), CW_LM_N);
        OP_OUT:                 cw = cw_on(cw_on(CW_INACTIVE, CW_EA), CW_LO_N);
        default:                cw = CW_INACTIVE;
      endcase
    end else if (t_state[4]) begin
      unique case (opcode)
        OP_LDA:  cw = cw_on(cw_on(CW_INACTIVE, CW_CE_N), CW_LA_N);
        OP_ADD:  cw = cw_on(cw_on(CW_INACTIVE, CW_CE_N), CW_LB_N);
        OP_SUB:  cw = cw_on(cw_on(cw_on(CW_INACTIVE, CW_CE_N), CW_LB_N), CW_SU);
        default: cw = CW_INACTIVE;
      endcase
    end else if (t_state[5]) begin
      unique case (opcode)
        OP_ADD:  cw = cw_on(cw_on(CW_INACTIVE, CW_EU), CW_LA_N);
        OP_SUB:  cw = cw_on(cw_on(cw_on(CW_INACTIVE, CW_EU), CW_LA_N), CW_SU);
        default: cw = CW_INACTIVE;
      endcase
    end
  end

  assign control_word = cw;

endmodule
